alu_share_arb: RTL

//  Round-robin arbiter/sequencer sharing one combinational ALU between NREQ requesters.
//  - Accepts one operation per grant and registers its operands into the ALU.
//  - Captures the ALU outputs one cycle later.
//  - Returns the result to the granted requester with a valid/ready response.
//  - Sits between core-side users (e.g. exec unit, address gen) and the single alu instance.

---
 rtl/alu_share_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NREQ requesters.
// Latency: accept in cycle N, rsp_valid in N+2. Throughput is at most one op every 3 cycles.
// Backpressure: the result is held in RESP until rsp_ready[owner]; req_ready is zero outside IDLE.
//
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_ctr per requester;
//        rsp_valid (owner bit only)/rsp_ready/rsp_data/rsp_less/rsp_zero back to the owner;
//        alu_a/alu_b/alu_ctr registered toward the ALU, alu_out/alu_is_less/alu_is_zero from it.
// Optional: define ALU_ARB_PERF_EN to add the perf_ops / perf_stall counter outputs.
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_ctr,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_less,
  output logic               rsp_zero,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [3:0]         alu_ctr,
  input  logic [31:0]        alu_out,
  input  logic               alu_is_less,
  input  logic               alu_is_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall
`endif
);

  // With NREQ=1 the index width is zero; keep a 1-bit register that simply stays 0.
  localparam int OW = (IDW > 0) ? IDW : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q;
  logic [OW-1:0]   prio_q;
  logic [OW-1:0]   owner_q;
  logic [NREQ-1:0] rsp_vld_q;
  logic [31:0]     alu_a_q, alu_b_q, rsp_data_q;
  logic [3:0]      alu_ctr_q;
  logic            rsp_less_q, rsp_zero_q;

  logic            found;
  logic [OW-1:0]   win;
  logic [NREQ-1:0] grant;

  // Two passes give the wrap-around scan: first requesters at or above prio,
  // then from 0 upward.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (OW'(i) >= prio_q)) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
    if (found) grant[win] = 1'b1;
  end

  // Grant is combinational from state, prio and req_valid only; forced low in reset.
  assign req_ready = (state_q == S_IDLE && !rst) ? grant : '0;
  assign rsp_valid = rst ? '0 : rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_less  = rsp_less_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctr   = alu_ctr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= '0;
      owner_q    <= '0;
      rsp_vld_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctr_q  <= '0;
      rsp_data_q <= '0;
      rsp_less_q <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            alu_a_q   <= req_a[32*win +: 32];
            alu_b_q   <= req_b[32*win +: 32];
            alu_ctr_q <= req_ctr[4*win +: 4];
            owner_q   <= win;
            prio_q    <= (int'(win) == NREQ - 1) ? '0 : win + OW'(1);
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data_q         <= alu_out;
          rsp_less_q         <= alu_is_less;
          rsp_zero_q         <= alu_is_zero;
          rsp_vld_q          <= '0;
          rsp_vld_q[owner_q] <= 1'b1;
          state_q            <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's ready bit completes the handshake.
          if (rsp_ready[owner_q]) begin
            rsp_vld_q <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          rsp_vld_q <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (|req_ready) perf_ops_q <= perf_ops_q + 32'd1;
      if ((|req_valid) && !(|req_ready)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
